// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state type and default width for countdown_timer
package timer_pkg;

    // Default bit width of the count, load value and reload register
    localparam int DEFAULT_WIDTH = 8;

    // Controller states; busy is asserted in ST_RUN and ST_PAUSED only
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // True while a countdown is in progress (running or frozen)
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSED);
    endfunction

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable countdown timer, one-shot or periodic (COUNTDOWN_TIMER_AUTO_RELOAD_EN)
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] next_reload;
    logic             next_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath decisions; load overrides pause, pause overrides start, start overrides en
    always_comb begin
        next_state  = state;
        next_count  = count;
        next_reload = reload;
        next_done   = 1'b0;

        if (load) begin
            // A load always lands in IDLE and never produces a done pulse
            next_count  = load_val;
            next_reload = load_val;
            next_state  = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Nothing to count down from zero, so start is ignored then
                    if (start && (count != '0)) begin
                        next_state = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (pause) begin
                        next_state = ST_PAUSED;
                    end else if (en) begin
                        if (count > ONE) begin
                            next_count = count - ONE;
                        end else if (count == ONE) begin
                            // Terminal count: done is registered alongside the new count
                            next_done = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                            next_count = reload;
`else
                            next_count = '0;
                            next_state = ST_DONE;
`endif
                        end
                        // count == 0 in RUN is unreachable; holding avoids any wrap
                    end
                end

                ST_PAUSED: begin
                    if (!pause && start) begin
                        next_state = ST_RUN;
                    end
                end

                ST_DONE: begin
                    // Restart from the last loaded value; a zero reload would finish instantly
                    if (start && (reload != '0)) begin
                        next_count = reload;
                        next_state = ST_RUN;
                    end
                end

                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Registered datapath: count, reload register and the done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            count  <= next_count;
            reload <= next_reload;
            done   <= next_done;
        end
    end

    assign busy = state_is_busy(state);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - table-driven scoreboard bench for countdown_timer
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] count;
    logic       busy;
    logic       done;

    countdown_timer #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       ld;
        logic [7:0] lv;
        logic       st;
        logic       pa;
        logic       e;
        logic [7:0] c;
        logic       b;
        logic       d;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] c;
        logic       b;
        logic       d;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   passed = 0;
    int   total = 0;

    function automatic void add(input string nm, input logic r, input logic l,
                                input logic [7:0] lv, input logic s, input logic p,
                                input logic e, input logic [7:0] c, input logic b,
                                input logic d);
        vec_t v;
        v.name = nm; v.rst = r; v.ld = l; v.lv = lv; v.st = s; v.pa = p; v.e = e;
        v.c = c; v.b = b; v.d = d;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    initial begin
        // name            rst ld lv    st pa en  count b  d
        add("reset",        1, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        add("idle_en",      0, 0, 8'd0, 0, 0, 1, 8'd0, 0, 0);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        add("ar_load3",     0, 1, 8'd3, 0, 0, 0, 8'd3, 0, 0);
        add("ar_start",     0, 0, 8'd0, 1, 0, 0, 8'd3, 1, 0);
        for (int k = 0; k < 3; k++) begin
            add("ar_2",     0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 0);
            add("ar_1",     0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0);
            add("ar_reload",0, 0, 8'd0, 0, 0, 1, 8'd3, 1, 1);
        end
        add("ar_hold",      0, 0, 8'd0, 0, 0, 0, 8'd3, 1, 0);
`else
        // Five-cycle one-shot
        add("os_load5",     0, 1, 8'd5, 0, 0, 0, 8'd5, 0, 0);
        add("os_start",     0, 0, 8'd0, 1, 0, 0, 8'd5, 1, 0);
        add("os_4",         0, 0, 8'd0, 0, 0, 1, 8'd4, 1, 0);
        add("os_3",         0, 0, 8'd0, 0, 0, 1, 8'd3, 1, 0);
        add("os_hold",      0, 0, 8'd0, 0, 0, 0, 8'd3, 1, 0);
        add("os_2",         0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 0);
        add("os_1",         0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0);
        add("os_term",      0, 0, 8'd0, 0, 0, 1, 8'd0, 0, 1);
        add("os_after",     0, 0, 8'd0, 0, 0, 1, 8'd0, 0, 0);
        // Restart from DONE reloads the last load value
        add("rs_start",     0, 0, 8'd0, 1, 0, 1, 8'd5, 1, 0);
        add("rs_4",         0, 0, 8'd0, 0, 0, 1, 8'd4, 1, 0);
        add("rs_3",         0, 0, 8'd0, 0, 0, 1, 8'd3, 1, 0);
        add("rs_2",         0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 0);
        add("rs_1",         0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0);
        add("rs_term",      0, 0, 8'd0, 0, 0, 1, 8'd0, 0, 1);
        // Pause at 2 for four cycles, including a start while still paused
        add("pz_load3",     0, 1, 8'd3, 0, 0, 0, 8'd3, 0, 0);
        add("pz_start",     0, 0, 8'd0, 1, 0, 0, 8'd3, 1, 0);
        add("pz_2",         0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 0);
        add("pz_pause_en",  0, 0, 8'd0, 0, 1, 1, 8'd2, 1, 0);
        add("pz_held",      0, 0, 8'd0, 0, 1, 1, 8'd2, 1, 0);
        add("pz_pause_st",  0, 0, 8'd0, 1, 1, 1, 8'd2, 1, 0);
        add("pz_en_only",   0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 0);
        add("pz_resume",    0, 0, 8'd0, 1, 0, 1, 8'd2, 1, 0);
        add("pz_1",         0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0);
        add("pz_term",      0, 0, 8'd0, 0, 0, 1, 8'd0, 0, 1);
        // Zero load cannot start; a later non-zero load can
        add("z_load0",      0, 1, 8'd0, 0, 0, 0, 8'd0, 0, 0);
        add("z_start",      0, 0, 8'd0, 1, 0, 1, 8'd0, 0, 0);
        add("z_stay",       0, 0, 8'd0, 0, 0, 1, 8'd0, 0, 0);
        add("z_load2",      0, 1, 8'd2, 0, 0, 0, 8'd2, 0, 0);
        add("z_start2",     0, 0, 8'd0, 1, 0, 0, 8'd2, 1, 0);
        add("z_1",          0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0);
        add("z_term",       0, 0, 8'd0, 0, 0, 1, 8'd0, 0, 1);
        // Load on the terminal cycle suppresses done
        add("ls_load2",     0, 1, 8'd2, 0, 0, 0, 8'd2, 0, 0);
        add("ls_start",     0, 0, 8'd0, 1, 0, 0, 8'd2, 1, 0);
        add("ls_1",         0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0);
        add("ls_load7",     0, 1, 8'd7, 0, 0, 1, 8'd7, 0, 0);
`endif
        // Reset mid-count aborts with no done
        add("rm_load4",     0, 1, 8'd4, 0, 0, 0, 8'd4, 0, 0);
        add("rm_start",     0, 0, 8'd0, 1, 0, 0, 8'd4, 1, 0);
        add("rm_3",         0, 0, 8'd0, 0, 0, 1, 8'd3, 1, 0);
        add("rm_2",         0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 0);
        add("rm_reset",     1, 0, 8'd0, 0, 0, 1, 8'd0, 0, 0);
        add("rm_quiet",     0, 0, 8'd0, 0, 0, 1, 8'd0, 0, 0);
        // Load mid-count returns to IDLE with the new value
        add("lm_load4",     0, 1, 8'd4, 0, 0, 0, 8'd4, 0, 0);
        add("lm_start",     0, 0, 8'd0, 1, 0, 0, 8'd4, 1, 0);
        add("lm_3",         0, 0, 8'd0, 0, 0, 1, 8'd3, 1, 0);
        add("lm_2",         0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 0);
        add("lm_load",      0, 1, 8'd4, 0, 0, 1, 8'd4, 0, 0);
        add("lm_idle_en",   0, 0, 8'd0, 0, 0, 1, 8'd4, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t x;
            @(negedge clk);
            reset    = vecs[i].rst;
            load     = vecs[i].ld;
            load_val = vecs[i].lv;
            start    = vecs[i].st;
            pause    = vecs[i].pa;
            en       = vecs[i].e;
            x.name = vecs[i].name; x.c = vecs[i].c; x.b = vecs[i].b; x.d = vecs[i].d;
            exp_q.push_back(x);
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk({x.name, ".count"}, int'(count), int'(x.c));
                chk({x.name, ".busy"}, int'(busy), int'(x.b));
                chk({x.name, ".done"}, int'(done), int'(x.d));
            end
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
